// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing a single level-enable, combinational-read data RAM.
// Every access runs IDLE -> SETUP -> STROBE -> DONE so address and data are
// stable around the LE pulse. Round-robin arbitration by default; defining
// ARB_FIXED_PRIO_EN selects fixed priority with requester A always winning.
module data_mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          mem_le,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

  state_e state_q;
  logic   win_b_q;  // latched winner: 1 = B, 0 = A
  logic   we_q;     // latched write select of the winner
  logic   pick_b;   // arbitration result in IDLE

`ifdef ARB_FIXED_PRIO_EN
  // A always wins a tie; B is served only when A is idle.
  always_comb begin
    pick_b = ~a_req;
  end
`else
  logic last_win_b_q;  // 1 = B won the previous access

  // Round-robin: a tie goes to the port that did not win last time.
  always_comb begin
    pick_b = b_req & (~a_req | ~last_win_b_q);
  end
`endif

  // Access sequencer; all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StIdle;
      win_b_q      <= 1'b0;
      we_q         <= 1'b0;
      mem_le       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      busy         <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_win_b_q <= 1'b1;
`endif
    end else begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            win_b_q   <= pick_b;
            we_q      <= pick_b ? b_we : a_we;
            mem_addr  <= pick_b ? b_addr : a_addr;
            mem_wdata <= pick_b ? b_wdata : a_wdata;
            busy      <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          mem_le  <= we_q;
          state_q <= StStrobe;
        end
        StStrobe: begin
          mem_le <= 1'b0;
          if (!we_q) begin
            if (win_b_q) begin
              b_rdata <= mem_rdata;
            end else begin
              a_rdata <= mem_rdata;
            end
          end
          // gnt is raised here so it is high for exactly the DONE cycle.
          if (win_b_q) begin
            b_gnt <= 1'b1;
          end else begin
            a_gnt <= 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
`ifndef ARB_FIXED_PRIO_EN
          last_win_b_q <= win_b_q;
`endif
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural RAM model and a
// scoreboard of expected grants.
module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt;
  logic [DW-1:0] b_rdata;
  logic          mem_le;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rdata  (b_rdata),
    .mem_le   (mem_le),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  // RAM model: combinational read, write while LE is high.
  logic [DW-1:0] ram [256];
  assign mem_rdata = ram[mem_addr];
  always @(posedge Clk) if (mem_le) ram[mem_addr] = mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;
  txn_t sb[$];

  // Protocol invariants checked every cycle outside reset.
  always @(negedge Clk) begin
    if (!Rst) begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL both_gnt t=%0t a_gnt=%b b_gnt=%b want not both", $time, a_gnt, b_gnt);
      end
      checks++;
      if (mem_le && (!busy || a_gnt || b_gnt)) begin
        errors++;
        $display("FAIL le_outside_strobe t=%0t le=%b busy=%b gnt=%b%b", $time, mem_le, busy,
                 a_gnt, b_gnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || mem_le !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
        a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals busy=%b le=%b addr=%h wd=%h gnt=%b%b rd=%h/%h want all 0",
               busy, mem_le, mem_addr, mem_wdata, a_gnt, b_gnt, a_rdata, b_rdata);
    end
    Rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b gnt=%b%b want 0 00", busy, a_gnt, b_gnt);
    end
  endtask

  task automatic test_write_a();
    txn_t t;
    sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 8'h10, data: 8'h5A});
    a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h5A; a_req = 1'b1;
    tick();  // k+1 SETUP
    checks++;
    if (busy !== 1'b1 || mem_le !== 1'b0 || mem_addr !== 8'h10 || a_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_setup busy=%b le=%b addr=%h gnt=%b want 1 0 10 0", busy, mem_le,
               mem_addr, a_gnt);
    end
    tick();  // k+2 STROBE
    checks++;
    if (mem_le !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h5A || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_strobe le=%b addr=%h wd=%h busy=%b want 1 10 5a 1", mem_le, mem_addr,
               mem_wdata, busy);
    end
    tick();  // k+3 DONE
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_le !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_done gnt=%b%b le=%b busy=%b want 10 0 1", a_gnt, b_gnt, mem_le, busy);
    end
    t = sb.pop_front();
    checks++;
    if (ram[t.addr] !== t.data) begin
      errors++;
      $display("FAIL wr_ram got=%h want=%h", ram[t.addr], t.data);
    end
    a_req = 1'b0;
    tick();
    checks++;
    if (a_gnt !== 1'b0 || busy !== 1'b0 || mem_le !== 1'b0) begin
      errors++;
      $display("FAIL wr_after gnt=%b busy=%b le=%b want 0 0 0", a_gnt, busy, mem_le);
    end
  endtask

  task automatic test_read_b();
    txn_t t;
    bit   le_seen = 1'b0;
    sb.push_back('{port_b: 1'b1, we: 1'b0, addr: 8'h10, data: 8'h5A});
    b_we = 1'b0; b_addr = 8'h10; b_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (mem_le) le_seen = 1'b1;
    end
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rd_gnt_k3 gnt=%b%b want 01", a_gnt, b_gnt);
    end
    t = sb.pop_front();
    checks++;
    if (b_rdata !== t.data) begin
      errors++;
      $display("FAIL rd_data got=%h want=%h", b_rdata, t.data);
    end
    checks++;
    if (le_seen || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_side le_seen=%b a_rdata=%h want 0 00", le_seen, a_rdata);
    end
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    txn_t t;
    int   n = 0;
    int   last_cyc = 0;
    int   start = cyc;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 8'h20, data: 8'h11});
`else
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 8'h20, data: 8'h11});
      sb.push_back('{port_b: 1'b1, we: 1'b0, addr: 8'h10, data: 8'h5A});
    end
`endif
    a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'h11;
    b_we = 1'b0; b_addr = 8'h10;
    a_req = 1'b1; b_req = 1'b1;
    while (n < 4 && cyc - start < 40) begin
      tick();
      if (a_gnt || b_gnt) begin
        t = sb.pop_front();
        checks++;
        if (b_gnt !== t.port_b) begin
          errors++;
          $display("FAIL rr_order n=%0d got_b=%b want_b=%b", n, b_gnt, t.port_b);
        end
        checks++;
        if (t.we ? (ram[t.addr] !== t.data) : (b_rdata !== t.data)) begin
          errors++;
          $display("FAIL rr_data n=%0d ram=%h b_rdata=%h want=%h", n, ram[t.addr], b_rdata,
                   t.data);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 4) begin
            errors++;
            $display("FAIL rr_spacing n=%0d got=%0d want=4", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
        if (n == 4) begin
          a_req = 1'b0;
          b_req = 1'b0;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_timeout grants=%0d want=4", n);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    b_we = 1'b0; b_addr = 8'h10; b_req = 1'b1;
    tick();  // SETUP
    tick();  // STROBE
    Rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_le !== 1'b0 || b_gnt !== 1'b0 || b_rdata !== 8'h00 ||
        a_rdata !== 8'h00 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid busy=%b le=%b b_gnt=%b b_rd=%h a_rd=%h addr=%h want 0 0 0 00 00 00",
               busy, mem_le, b_gnt, b_rdata, a_rdata, mem_addr);
    end
    Rst = 1'b0;
    b_req = 1'b0;
    tick();
    checks++;
    if (b_gnt !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after b_gnt=%b busy=%b want 0 0", b_gnt, busy);
    end
  endtask

  task automatic test_addr_latch();
    txn_t t;
    sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 8'hFF, data: 8'hC3});
    a_we = 1'b1; a_addr = 8'hFF; a_wdata = 8'hC3; a_req = 1'b1;
    tick();  // SETUP: winner inputs may now change
    a_addr = 8'h00; a_wdata = 8'h00;
    checks++;
    if (mem_addr !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL latch_setup addr=%h busy=%b want ff 1", mem_addr, busy);
    end
    tick();  // STROBE
    checks++;
    if (mem_le !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL latch_strobe le=%b addr=%h wd=%h want 1 ff c3", mem_le, mem_addr, mem_wdata);
    end
    tick();  // DONE
    t = sb.pop_front();
    checks++;
    if (a_gnt !== 1'b1 || mem_addr !== 8'hFF || ram[t.addr] !== t.data || ram[0] !== 8'h00) begin
      errors++;
      $display("FAIL latch_done gnt=%b addr=%h ram_ff=%h ram_00=%h want 1 ff c3 00", a_gnt,
               mem_addr, ram[t.addr], ram[0]);
    end
    a_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_reset_mid();
    test_addr_latch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover size=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-port arbiter that shares the single 8-bit data RAM (level-enable write, combinational read) between requester A (processor-side load/store unit) and requester B (debug/DMA loader).
- Sequences every access through a fixed 4-state strobe so the RAM sees a stable address and data while LE is high.
- Sits between the requesters and the data memory's LE/i_data/address_data/o_data pins.
- Default arbitration is round-robin.

Parameters:
AW, 8, address width
DW, 8, data width

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous, active-high reset
a_req  in  1  requester A access request; held high until a_gnt
a_we  in  1  A: 1=write, 0=read; stable while a_req high
a_addr  in  AW  A address
a_wdata  in  DW  A write data
a_gnt  out  1  A one-cycle completion pulse
a_rdata  out  DW  A read data, valid in a_gnt cycle
b_req  in  1  requester B request, same rules as A
b_we  in  1  B write select
b_addr  in  AW  B address
b_wdata  in  DW  B write data
b_gnt  out  1  B completion pulse
b_rdata  out  DW  B read data, valid in b_gnt cycle
mem_le  out  1  RAM write enable (to LE)
mem_addr  out  AW  RAM address (to address_data)
mem_wdata  out  DW  RAM write data (to i_data)
mem_rdata  in  DW  RAM read data (from o_data)
busy  out  1  high in SETUP, STROBE, DONE

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE.
  - mem_le=0, mem_addr=0, mem_wdata=0.
  - a_gnt=b_gnt=0, a_rdata=b_rdata=0, busy=0.
  - last_winner=B, so A wins the first tie.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick winner. Only one requesting -> that one. Both -> the port that is not last_winner.
  - Latch winner id, we, addr, wdata. Load mem_addr and mem_wdata. Go to SETUP.
- SETUP (1 cycle): mem_addr/mem_wdata stable, mem_le=0. Set mem_le=1 at exit only if latched we=1. Go to STROBE.
- STROBE (1 cycle):
  - mem_le = latched we.
  - At exit: clear mem_le. For a read, capture mem_rdata into the winner's rdata register; the other port's rdata is unchanged.
  - Go to DONE.
- DONE (1 cycle):
  - mem_le=0, address held.
  - Winner's gnt=1. last_winner updated to winner.
  - Go to IDLE.
- Timing: req high in IDLE cycle k -> gnt in cycle k+3. Throughput is one access per 4 cycles when both ports are saturated (IDLE, SETUP, STROBE, DONE).
- Requester rules:
  - Requester drops req in the cycle after gnt, or issues a new request by keeping req high.
  - A req still high in the IDLE following its own gnt is a new request.
  - Under round-robin, that port loses to a pending other port.
- Loser's req and inputs are ignored until it wins. Changes to the loser's inputs are allowed.
- A winner's inputs may change after the IDLE exit; the latched copies are used.
- Never both gnt high in the same cycle. mem_le is never high outside STROBE.
- Reset mid-operation: Rst in any state returns to IDLE at the next edge with reset values.
  - No gnt is issued for the aborted access.
  - A write whose STROBE cycle had already begun is considered performed.
- Address wrap: none. AW bits are passed straight through.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: fixed priority; A always wins when both request, and last_winner is unused. B can starve.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
1. Reset, then a_req=1, a_we=1, a_addr=0x10, a_wdata=0x5A.
   -> mem_le=1 only in cycle k+2 with mem_addr=0x10, mem_wdata=0x5A. a_gnt pulse in k+3. busy high k+1..k+3.
2. RAM holds 0x5A at 0x10; b_req read of 0x10.
   -> b_gnt at k+3 with b_rdata=0x5A. mem_le stays 0 throughout. a_rdata unchanged.
3. a_req and b_req both rise in the same IDLE cycle, both held.
   -> grant order A, B, A, B. Consecutive gnts 4 cycles apart. Never both gnts high together.
   -> With ARB_FIXED_PRIO_EN: A, A, A... while a_req is held.
4. Rst asserted during the STROBE cycle of a B read.
   -> next cycle: IDLE, busy=0, mem_le=0, no b_gnt, b_rdata=0.
5. A write to 0xFF with a_addr/a_wdata changed to 0x00/0x00 right after the IDLE exit.
   -> RAM[0xFF] receives the original data. mem_addr stays 0xFF through DONE.
